uart_prg_loader: RTL and testbench



---
 rtl/prg_loader_pkg.sv | 7 +
 rtl/uart_prg_loader_if.sv | 25 ++
 rtl/prg_timeout.sv | 16 +
 rtl/uart_prg_loader.sv | 119 +++++++++++
 tb/tb_uart_prg_loader.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/prg_loader_pkg.sv
// prg_loader_pkg: shared FSM state encoding and protocol byte constants for the program loader.
package prg_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, CSUM, ACK, NAK, WAIT_TX} state_e;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/uart_prg_loader_if.sv
// uart_prg_loader_if: rx byte stream, memory write port, tx response and status of the loader.
interface uart_prg_loader_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 12
);
  logic                  i_rx_valid;
  logic [7:0]            i_rx_byte;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_data;
  logic                  o_mem_we;
  logic                  o_core_hold;
  logic                  o_tx_valid;
  logic [7:0]            o_tx_byte;
  logic                  i_tx_done;
  logic                  o_busy;
  logic                  o_error;
  modport slave (
    input  i_rx_valid, i_rx_byte, i_tx_done,
    output o_mem_addr, o_mem_data, o_mem_we, o_core_hold, o_tx_valid, o_tx_byte, o_busy, o_error
  );
  modport master (
    output i_rx_valid, i_rx_byte, i_tx_done,
    input  o_mem_addr, o_mem_data, o_mem_we, o_core_hold, o_tx_valid, o_tx_byte, o_busy, o_error
  );
endinterface

// File: rtl/prg_timeout.sv
// prg_timeout: reloadable down-counter; expired once TIMEOUT cycles pass while running without a reload.
module prg_timeout #(
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic reload,
  output logic expired
);
  localparam int unsigned W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (reload || !run) ? W'(TIMEOUT - 1) : (cnt_q == '0 ? cnt_q : cnt_q - W'(1));
  assign expired = run && cnt_q == '0;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_prg_loader.sv
// uart_prg_loader: parses SYNC/LEN/(HI,LO)*/CSUM frames from the UART into memory and answers ACK/NAK.
module uart_prg_loader import prg_loader_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned MEM_COUNT  = 255,
  parameter int unsigned TIMEOUT    = 2000000,
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input logic clk,
  input logic reset,
  uart_prg_loader_if.slave bus
);
  state_e                state_q, state_d;
  logic [7:0]            len_q, len_d, idx_q, idx_d, csum_q, csum_d;
  logic [3:0]            hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  we_q, we_d, hold_q, hold_d, busy_q, busy_d, err_q, err_d;
  logic                  run, expired;
  logic                  rxv;
  logic [7:0]            rxb;
  assign rxv = bus.i_rx_valid;
  assign rxb = bus.i_rx_byte;
  assign run = state_q inside {LEN, HI, LO, CSUM};
  prg_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(clk), .reset(reset), .run(run), .reload(rxv), .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (rxv && rxb == SYNC_BYTE) begin
        state_d = LEN;
        busy_d  = 1'b1;
        hold_d  = 1'b1;
        idx_d   = '0;
        csum_d  = '0;
      end
      LEN: if (rxv) begin
        len_d   = rxb;
        state_d = (rxb == '0 || 32'(rxb) > MEM_COUNT) ? NAK : HI;
      end
      HI: if (rxv) begin
        hi_d    = rxb[3:0];
        csum_d  = csum_q ^ rxb;
        state_d = rxb[7:4] != '0 ? NAK : LO;
      end
      LO: if (rxv) begin
        csum_d  = csum_q ^ rxb;
        we_d    = 1'b1;
        addr_d  = ADDR_WIDTH'(idx_q);
        data_d  = DATA_WIDTH'({hi_q, rxb});
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q + 8'd1 == len_q) ? CSUM : HI;
      end
      CSUM: if (rxv) state_d = rxb == csum_q ? ACK : NAK;
      ACK: begin
        hold_d  = 1'b0;
        err_d   = 1'b0;
        state_d = WAIT_TX;
      end
      NAK: begin
        err_d   = 1'b1;
        state_d = WAIT_TX;
      end
      WAIT_TX: if (bus.i_tx_done) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // a byte arriving in the expiry cycle takes priority over the timeout
    if (run && !rxv && expired) state_d = NAK;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_data  = data_q;
  assign bus.o_mem_we    = we_q;
  assign bus.o_core_hold = hold_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_error     = err_q;
  assign bus.o_tx_valid  = state_q == ACK || state_q == NAK;
  assign bus.o_tx_byte   = state_q == ACK ? ACK_BYTE : state_q == NAK ? NAK_BYTE : 8'h00;
endmodule

// File: tb/tb_uart_prg_loader.sv
// tb_uart_prg_loader: directed frame scenarios with hand-computed memory and response expectations.
module tb_uart_prg_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  logic [11:0] mem [0:255];
  uart_prg_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) bus ();
  uart_prg_loader #(.ADDR_WIDTH(12), .DATA_WIDTH(12), .MEM_COUNT(255), .TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.o_mem_we) begin
    mem[bus.o_mem_addr[7:0]] <= bus.o_mem_data;
    we_cnt <= we_cnt + 1;
  end
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_byte  = b;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    bus.i_rx_byte  = 8'h00;
  endtask
  task automatic finish_tx();
    @(negedge clk);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.o_busy, bus.o_core_hold, bus.o_error, bus.o_mem_we, bus.o_tx_valid, bus.o_tx_byte, bus.o_mem_addr, bus.o_mem_data} !== 37'd0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b hold=%b err=%b we=%b txv=%b, required all 0", bus.o_busy, bus.o_core_hold, bus.o_error, bus.o_mem_we, bus.o_tx_valid);
    end
    reset = 1'b0;
  endtask
  task automatic test_good_frame();
    int w0;
    w0 = we_cnt;
    send_byte(8'hA5);
    tests++;
    if ({bus.o_busy, bus.o_core_hold} !== 2'b11) begin fails++; $display("FAIL good_busy_hold: got %b%b required 11", bus.o_busy, bus.o_core_hold); end
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h23);
    tests++;
    if ({bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data} !== {1'b1, 12'h000, 12'h123}) begin fails++; $display("FAIL good_word0: got we=%b addr=%h data=%h required 1 000 123", bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data); end
    send_byte(8'h00);
    send_byte(8'hFF);
    tests++;
    if ({bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data} !== {1'b1, 12'h001, 12'h0FF}) begin fails++; $display("FAIL good_word1: got we=%b addr=%h data=%h required 1 001 0ff", bus.o_mem_we, bus.o_mem_addr, bus.o_mem_data); end
    send_byte(8'hDD);
    tests++;
    if ({bus.o_tx_valid, bus.o_tx_byte, bus.o_core_hold} !== {1'b1, 8'h06, 1'b1}) begin fails++; $display("FAIL good_ack: got txv=%b byte=%h hold=%b required 1 06 1", bus.o_tx_valid, bus.o_tx_byte, bus.o_core_hold); end
    @(negedge clk);
    tests++;
    if ({bus.o_tx_valid, bus.o_core_hold, bus.o_error, bus.o_busy} !== 4'b0001) begin fails++; $display("FAIL good_after_ack: got txv/hold/err/busy=%b required 0001", {bus.o_tx_valid, bus.o_core_hold, bus.o_error, bus.o_busy}); end
    finish_tx();
    tests++;
    if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL good_idle_busy: got %b required 0", bus.o_busy); end
    tests++;
    if ({we_cnt - w0, mem[0], mem[1]} !== {32'd2, 12'h123, 12'h0FF}) begin fails++; $display("FAIL good_mem: got writes=%0d m0=%h m1=%h required 2 123 0ff", we_cnt - w0, mem[0], mem[1]); end
  endtask
  task automatic test_bad_csum();
    int w0;
    w0 = we_cnt;
    mem[0] = 12'h000;
    mem[1] = 12'h000;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h23); send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'h00);
    tests++;
    if ({bus.o_tx_valid, bus.o_tx_byte} !== {1'b1, 8'h15}) begin fails++; $display("FAIL csum_nak: got txv=%b byte=%h required 1 15", bus.o_tx_valid, bus.o_tx_byte); end
    @(negedge clk);
    tests++;
    if ({bus.o_error, bus.o_core_hold} !== 2'b11) begin fails++; $display("FAIL csum_err_hold: got err=%b hold=%b required 1 1", bus.o_error, bus.o_core_hold); end
    finish_tx();
    tests++;
    if ({we_cnt - w0, mem[0], mem[1]} !== {32'd2, 12'h123, 12'h0FF}) begin fails++; $display("FAIL csum_mem_kept: got writes=%0d m0=%h m1=%h required 2 123 0ff", we_cnt - w0, mem[0], mem[1]); end
  endtask
  task automatic test_len_zero();
    int w0;
    w0 = we_cnt;
    send_byte(8'hA5); send_byte(8'h00);
    tests++;
    if ({bus.o_tx_valid, bus.o_tx_byte, we_cnt - w0} !== {1'b1, 8'h15, 32'd0}) begin fails++; $display("FAIL len0_nak: got txv=%b byte=%h writes=%0d required 1 15 0", bus.o_tx_valid, bus.o_tx_byte, we_cnt - w0); end
    finish_tx();
  endtask
  task automatic test_bad_hi();
    int w0;
    w0 = we_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
    tests++;
    if ({bus.o_tx_valid, bus.o_tx_byte} !== {1'b1, 8'h15}) begin fails++; $display("FAIL badhi_nak: got txv=%b byte=%h required 1 15", bus.o_tx_valid, bus.o_tx_byte); end
    @(negedge clk);
    tests++;
    if ({bus.o_mem_we, we_cnt - w0} !== {1'b0, 32'd0}) begin fails++; $display("FAIL badhi_nowrite: got we=%b writes=%0d required 0 0", bus.o_mem_we, we_cnt - w0); end
    finish_tx();
  endtask
  task automatic test_mid_reset();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h02); send_byte(8'h34);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.o_busy, bus.o_core_hold, bus.o_error, bus.o_mem_we, bus.o_tx_valid, bus.o_tx_byte, bus.o_mem_addr, bus.o_mem_data} !== 37'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got busy=%b hold=%b err=%b we=%b txv=%b addr=%h data=%h, required all 0", bus.o_busy, bus.o_core_hold, bus.o_error, bus.o_mem_we, bus.o_tx_valid, bus.o_mem_addr, bus.o_mem_data);
    end
    reset = 1'b0;
    tests++;
    if (mem[0] !== 12'h234) begin fails++; $display("FAIL midreset_mem0: got %h required 234", mem[0]); end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h0A); send_byte(8'hBC); send_byte(8'hB6);
    tests++;
    if ({bus.o_tx_valid, bus.o_tx_byte} !== {1'b1, 8'h06}) begin fails++; $display("FAIL midreset_reload_ack: got txv=%b byte=%h required 1 06", bus.o_tx_valid, bus.o_tx_byte); end
    finish_tx();
    tests++;
    if ({mem[0], bus.o_core_hold, bus.o_error} !== {12'hABC, 2'b00}) begin fails++; $display("FAIL midreset_reload_mem: got m0=%h hold=%b err=%b required abc 0 0", mem[0], bus.o_core_hold, bus.o_error); end
  endtask
  task automatic test_timeout();
    logic early;
    early = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (bus.o_tx_valid) early = 1'b1;
    end
    tests++;
    if (early !== 1'b0) begin fails++; $display("FAIL timeout_early: got early response=%b required 0", early); end
    @(negedge clk);
    tests++;
    if ({bus.o_tx_valid, bus.o_tx_byte} !== {1'b1, 8'h15}) begin fails++; $display("FAIL timeout_nak: got txv=%b byte=%h required 1 15", bus.o_tx_valid, bus.o_tx_byte); end
    finish_tx();
  endtask
  task automatic test_timeout_rescue();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    repeat (98) @(negedge clk);
    send_byte(8'h00);
    tests++;
    if ({bus.o_tx_valid, bus.o_mem_we, bus.o_mem_data} !== {1'b0, 1'b1, 12'h100}) begin fails++; $display("FAIL rescue_byte_wins: got txv=%b we=%b data=%h required 0 1 100", bus.o_tx_valid, bus.o_mem_we, bus.o_mem_data); end
    send_byte(8'h01);
    tests++;
    if ({bus.o_tx_valid, bus.o_tx_byte} !== {1'b1, 8'h06}) begin fails++; $display("FAIL rescue_ack: got txv=%b byte=%h required 1 06", bus.o_tx_valid, bus.o_tx_byte); end
    finish_tx();
  endtask
  task automatic test_len_max();
    int w0;
    w0 = we_cnt;
    send_byte(8'hA5); send_byte(8'hFF);
    tests++;
    if (bus.o_tx_valid !== 1'b0) begin fails++; $display("FAIL lenmax_accept: got txv=%b required 0", bus.o_tx_valid); end
    for (int i = 0; i < 255; i++) begin
      send_byte(8'h00);
      send_byte(i[7:0]);
    end
    send_byte(8'hFF);
    tests++;
    if ({bus.o_tx_valid, bus.o_tx_byte} !== {1'b1, 8'h06}) begin fails++; $display("FAIL lenmax_ack: got txv=%b byte=%h required 1 06", bus.o_tx_valid, bus.o_tx_byte); end
    finish_tx();
    tests++;
    if ({we_cnt - w0, mem[254], mem[7]} !== {32'd255, 12'h0FE, 12'h007}) begin fails++; $display("FAIL lenmax_mem: got writes=%0d m254=%h m7=%h required 255 0fe 007", we_cnt - w0, mem[254], mem[7]); end
  endtask
  initial begin
    bus.i_rx_valid = 1'b0;
    bus.i_rx_byte  = 8'h00;
    bus.i_tx_done  = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_zero();
    test_bad_hi();
    test_mid_reset();
    test_timeout();
    test_timeout_rescue();
    test_len_max();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
